// File: rtl/byteena_write_arbiter.sv
// Two-requester round-robin arbiter owning a byte-lane register.
// Optional BYTEENA_ARB_STATS_EN adds gcnt0/gcnt1 grant counters.
//
// Ports:
//   clk, resetn            clock, async active-low reset
//   req0/be0/wdata0        requester 0 request, lane mask, data
//   req1/be1/wdata1        requester 1 request, lane mask, data
//   gnt0, gnt1             one-cycle grants (decoded from state reg)
//   byteena                lanes written this cycle (granted be, else 0)
//   q                      stored register contents
//   busy                   FSM not idle
//   gcnt0, gcnt1           8-bit wrapping grant counters (stats only)
module byteena_write_arbiter #(
  parameter int NBYTES = 2,
  parameter logic [8*NBYTES-1:0] RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req0,
  input  logic [NBYTES-1:0]   be0,
  input  logic [8*NBYTES-1:0] wdata0,
  input  logic                req1,
  input  logic [NBYTES-1:0]   be1,
  input  logic [8*NBYTES-1:0] wdata1,
  output logic                gnt0,
  output logic                gnt1,
  output logic [NBYTES-1:0]   byteena,
  output logic [8*NBYTES-1:0] q,
  output logic                busy
`ifdef BYTEENA_ARB_STATS_EN
  ,
  output logic [7:0]          gcnt0,
  output logic [7:0]          gcnt1
`endif
);

  localparam int W = 8 * NBYTES;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic         last;
  logic         last_nxt;
  logic [W-1:0] wsel;

  // The granted requester's own req is ignored: it is consumed
  // by the grant, so only the other side can chain back-to-back.
  always_comb begin
    state_nxt = IDLE;
    last_nxt  = last;
    case (state)
      IDLE: begin
        unique case (1'b1)
          req0 && req1:  state_nxt = last ? GNT0 : GNT1;
          req0 && !req1: state_nxt = GNT0;
          req1 && !req0: state_nxt = GNT1;
          default:       state_nxt = IDLE;
        endcase
      end
      GNT0: begin
        last_nxt = 1'b0;
        if (req1) state_nxt = GNT1;
      end
      GNT1: begin
        last_nxt = 1'b1;
        if (req0) state_nxt = GNT0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign gnt0 = (state == GNT0);
  assign gnt1 = (state == GNT1);
  assign busy = gnt0 | gnt1;

  always_comb begin
    byteena = '0;
    wsel    = wdata0;
    unique case (1'b1)
      gnt0: byteena = be0;
      gnt1: begin
        byteena = be1;
        wsel    = wdata1;
      end
      default: byteena = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      last  <= 1'b1;
      q     <= RESET_VAL;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      for (int i = 0; i < NBYTES; i++) begin
        if (byteena[i]) q[8*i +: 8] <= wsel[8*i +: 8];
      end
    end
  end

`ifdef BYTEENA_ARB_STATS_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gcnt0 <= '0;
      gcnt1 <= '0;
    end else begin
      if (gnt0) gcnt0 <= gcnt0 + 8'd1;
      if (gnt1) gcnt1 <= gcnt1 + 8'd1;
    end
  end
`endif

endmodule

// File: doc/byteena_write_arbiter.md
Name: byteena_write_arbiter

Overview:
- Two-requester round-robin arbiter that owns a byte-enabled data register (NBYTES byte lanes) and sequences single-beat byte-masked writes into it.
- Each requester presents req, a byte-enable mask and write data, and holds them until granted.
- The arbiter issues a one-cycle grant and applies the granted requester's lanes to the register.
- It sits between producer blocks and the shared byte-lane storage; it is the sole driver of that storage's byte enables.

Parameters:
- NBYTES, 2, number of byte lanes; data width is 8*NBYTES.
- RESET_VAL, 0, value loaded into q on reset (8*NBYTES bits).

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- req0  in  1  requester 0 write request, held until gnt0
- be0  in  NBYTES  requester 0 byte enables
- wdata0  in  8*NBYTES  requester 0 write data
- req1  in  1  requester 1 write request, held until gnt1
- be1  in  NBYTES  requester 1 byte enables
- wdata1  in  8*NBYTES  requester 1 write data
- gnt0  out  1  grant to requester 0, registered, one cycle per transfer
- gnt1  out  1  grant to requester 1, registered, one cycle per transfer
- byteena  out  NBYTES  lanes being written this cycle: be of the granted requester, else 0
- q  out  8*NBYTES  stored register contents
- busy  out  1  high when the FSM is not in IDLE

Behaviour:
- Reset (resetn low, asynchronous, immediate):
  - state=IDLE, gnt0=gnt1=0, byteena=0, busy=0, q=RESET_VAL.
  - Last-grant pointer is set to 1, so requester 0 wins the first tie.
- FSM states: IDLE, GNT0, GNT1. gntX=1 exactly while in GNTX.
- IDLE transitions:
  - Only reqX high -> GNTX.
  - Both high -> GNTX where X != last-grant.
  - Neither high -> stay in IDLE.
- GNTX transitions:
  - reqX is ignored for next-state; it is treated as consumed by this grant.
  - req of the other requester high -> GNT(other); this is a back-to-back transfer with no IDLE gap.
  - Otherwise -> IDLE.
  - last-grant is set to X on leaving GNTX.
- Handshake:
  - The transfer occurs in the cycle gntX is high; beX/wdataX are sampled in that cycle.
  - A requester deasserts req on the edge after seeing gnt.
  - req still high in a later cycle is a new request.
  - A requester therefore gets at most one grant per two cycles.
- Latency:
  - reqX first sampled high at edge N -> gntX high in cycle N+1 -> q updated at edge N+2.
  - Minimum 2 cycles from request to visible data.
- Write rule: at the edge ending GNTX, for each lane i with beX[i]=1, q[8i+7:8i] <= wdataX[8i+7:8i]. Lanes with beX[i]=0 hold their value.
- be all zeros: the grant is still issued and the FSM advances; q is unchanged.
- byteena = beX while in GNTX, else 0 (combinational from state and inputs).
- Reset mid-transfer: gnt drops without a clock edge, the pending write is discarded, and q returns to RESET_VAL.
- No illegal states: any unencoded state value decodes to IDLE on the next edge.

Optional Feature:
- Macro: BYTEENA_ARB_STATS_EN.
- When defined:
  - Adds outputs gcnt0 and gcnt1, each 8 bits.
  - Each is a per-requester grant counter that increments at the edge ending GNTX.
  - Counters wrap 255->0 and reset to 0 on resetn low.
- When undefined: the ports and counters are absent, and all other behaviour is identical.

Test Plan:
- Reset check: resetn=0 with no clock -> q=16'h0000, gnt0=gnt1=0, byteena=2'b00, busy=0.
- Single write:
  - Stimulus: req0=1, be0=2'b11, wdata0=16'hA5A5 sampled at edge N.
  - Response: gnt0=1 and byteena=2'b11 in cycle N+1; q=16'hA5A5 after edge N+2; then IDLE.
- Lane masking:
  - Start with q=16'hA5A5.
  - req1 with be1=2'b01, wdata1=16'h1234 -> q=16'hA534.
  - Then be1=2'b10, wdata1=16'hFF00 -> q=16'hFF34.
- Simultaneous requests from reset:
  - Stimulus: req0 with be0=2'b11, wdata0=16'h1111; req1 with be1=2'b11, wdata1=16'h2222.
  - Response: gnt0 then gnt1 in consecutive cycles with no IDLE between; final q=16'h2222.
- Continuous contention:
  - Stimulus: req0=req1=1 held for 8 cycles.
  - Response: grants alternate 0,1,0,1 with busy=1 throughout.
  - With BYTEENA_ARB_STATS_EN defined: gcnt0=gcnt1=4 at the end.
- Async reset mid-grant: resetn driven low midway through a GNT1 cycle -> gnt1 falls immediately, q=RESET_VAL, and the write is not applied.
